// File: rtl/ysyx_22050039_core_seq_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22050039_core_seq_pkg
// Shared definitions for the multi-cycle instruction sequencer:
//   - STATE_W        : width of the one-hot state vector
//   - state_e        : one-hot state encoding
//   - HALT_*         : halt_code values reported on halt
//   - is_wait_state  : states in which the handshake watchdog runs
// ---------------------------------------------------------------------------
package ysyx_22050039_core_seq_pkg;

  localparam int STATE_W = 10;

  typedef enum logic [STATE_W-1:0] {
    S_RESET    = 10'b00_0000_0001,
    S_IF_REQ   = 10'b00_0000_0010,
    S_IF_WAIT  = 10'b00_0000_0100,
    S_ID       = 10'b00_0000_1000,
    S_EX       = 10'b00_0001_0000,
    S_EX_WAIT  = 10'b00_0010_0000,
    S_MEM_REQ  = 10'b00_0100_0000,
    S_MEM_WAIT = 10'b00_1000_0000,
    S_WB       = 10'b01_0000_0000,
    S_HALT     = 10'b10_0000_0000
  } state_e;

  localparam logic [1:0] HALT_EBREAK  = 2'd0;
  localparam logic [1:0] HALT_INV     = 2'd1;
  localparam logic [1:0] HALT_TIMEOUT = 2'd2;

  // States that wait on an external handshake and are therefore watched.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_IF_REQ) || (s == S_IF_WAIT) || (s == S_EX_WAIT) ||
           (s == S_MEM_REQ) || (s == S_MEM_WAIT);
  endfunction

endpackage

// File: rtl/ysyx_22050039_watchdog.sv
// ---------------------------------------------------------------------------
// ysyx_22050039_watchdog
// Saturating handshake watchdog. Counts cycles while en is high, clears on
// clr, and never wraps.
// Ports:
//   clk     in  : core clock
//   rst     in  : asynchronous active-low reset
//   clr     in  : clear the count (state change)
//   en      in  : count this cycle (sequencer is in a wait state)
//   expired out : the count reaches TIMEOUT with this cycle
// ---------------------------------------------------------------------------
module ysyx_22050039_watchdog
  import ysyx_22050039_core_seq_pkg::*;
#(
  parameter int          TIMEOUT_W = 16,
  parameter int unsigned TIMEOUT   = 32'h0000_FFFF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT[TIMEOUT_W-1:0];
  localparam logic [TIMEOUT_W-1:0] ONE   = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  logic [TIMEOUT_W-1:0] r_cnt;
  logic [TIMEOUT_W-1:0] w_cnt_inc;

  // Saturate at all-ones instead of wrapping back to zero.
  assign w_cnt_inc = (r_cnt == {TIMEOUT_W{1'b1}}) ? r_cnt : r_cnt + ONE;

  // The cycle being spent now is counted: expiry fires in the cycle whose
  // increment makes the count equal TIMEOUT, so TIMEOUT wait cycles elapse
  // before the sequencer leaves for HALT.
  assign expired = en && (w_cnt_inc == LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_cnt_inc;
    end
  end

endmodule

// File: rtl/ysyx_22050039_core_seq.sv
// ---------------------------------------------------------------------------
// ysyx_22050039_core_seq
// Multi-cycle instruction sequencer for the RV64 core: fetch, decode,
// execute, memory, writeback. Owns all handshakes and stalls, gates the
// register/PC write enables to one pulse per retired instruction and halts
// on ebreak, invalid instruction or handshake timeout.
//
// Optional feature macro: YSYX_22050039_PERF_CNT_EN adds perf_cycle and
// perf_instret (64-bit, wrapping) outputs.
//
// Ports:
//   clk, rst (async, active-low)
//   ifu_req_valid/ifu_req_ready/ifu_resp_valid : instruction fetch handshake
//   inst_latch                                 : load instruction register
//   dec_wreg/wpc/mdu/load/store/ebreak/invalid : decoder flags
//   mdu_start/mdu_done                         : mul/div unit handshake
//   mem_req_valid/mem_req_ready/mem_resp_valid : load/store handshake
//   reg_wen, pc_wen, pc_redirect               : writeback enables
//   halted, halt_code                          : halt status (sticky)
// ---------------------------------------------------------------------------
module ysyx_22050039_core_seq
  import ysyx_22050039_core_seq_pkg::*;
#(
  parameter int          TIMEOUT_W = 16,
  parameter int unsigned TIMEOUT   = 32'h0000_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_resp_valid,
  output logic        inst_latch,
  input  logic        dec_wreg,
  input  logic        dec_wpc,
  input  logic        dec_mdu,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_ebreak,
  input  logic        dec_invalid,
  output logic        mdu_start,
  input  logic        mdu_done,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  output logic        reg_wen,
  output logic        pc_wen,
  output logic        pc_redirect,
  output logic        halted,
  output logic [1:0]  halt_code
`ifdef YSYX_22050039_PERF_CNT_EN
  ,
  output logic [63:0] perf_cycle,
  output logic [63:0] perf_instret
`endif
);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [1:0] w_halt_code_nxt;
  logic       w_inst_latch;
  logic       w_wd_clr;
  logic       w_wd_en;
  logic       w_wd_expired;

  assign w_wd_en  = is_wait_state(r_state);
  assign w_wd_clr = (w_state_nxt != r_state);

  ysyx_22050039_watchdog #(
    .TIMEOUT_W (TIMEOUT_W),
    .TIMEOUT   (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_wd_clr),
    .en      (w_wd_en),
    .expired (w_wd_expired)
  );

  // Next-state logic. A completing handshake is tested before the watchdog,
  // so a handshake that lands in the expiry cycle still proceeds.
  always_comb begin
    w_state_nxt     = r_state;
    w_halt_code_nxt = halt_code;
    w_inst_latch    = 1'b0;
    unique case (r_state)
      S_RESET: w_state_nxt = S_IF_REQ;
      S_IF_REQ: begin
        if (ifu_req_ready) begin
          if (ifu_resp_valid) begin
            w_inst_latch = 1'b1;
            w_state_nxt  = S_ID;
          end else begin
            w_state_nxt  = S_IF_WAIT;
          end
        end else if (w_wd_expired) begin
          w_state_nxt     = S_HALT;
          w_halt_code_nxt = HALT_TIMEOUT;
        end
      end
      S_IF_WAIT: begin
        if (ifu_resp_valid) begin
          w_inst_latch = 1'b1;
          w_state_nxt  = S_ID;
        end else if (w_wd_expired) begin
          w_state_nxt     = S_HALT;
          w_halt_code_nxt = HALT_TIMEOUT;
        end
      end
      S_ID: begin
        if (dec_invalid) begin
          w_state_nxt     = S_HALT;
          w_halt_code_nxt = HALT_INV;
        end else if (dec_ebreak) begin
          w_state_nxt     = S_HALT;
          w_halt_code_nxt = HALT_EBREAK;
        end else begin
          w_state_nxt     = S_EX;
        end
      end
      S_EX: begin
        if (dec_mdu)                    w_state_nxt = S_EX_WAIT;
        else if (dec_load || dec_store) w_state_nxt = S_MEM_REQ;
        else                            w_state_nxt = S_WB;
      end
      S_EX_WAIT: begin
        if (mdu_done) begin
          w_state_nxt = S_WB;
        end else if (w_wd_expired) begin
          w_state_nxt     = S_HALT;
          w_halt_code_nxt = HALT_TIMEOUT;
        end
      end
      S_MEM_REQ: begin
        if (mem_req_ready) begin
          // Stores and loads whose data arrives with the acceptance skip MEM_WAIT.
          if (dec_store || mem_resp_valid) w_state_nxt = S_WB;
          else                             w_state_nxt = S_MEM_WAIT;
        end else if (w_wd_expired) begin
          w_state_nxt     = S_HALT;
          w_halt_code_nxt = HALT_TIMEOUT;
        end
      end
      S_MEM_WAIT: begin
        if (mem_resp_valid) begin
          w_state_nxt = S_WB;
        end else if (w_wd_expired) begin
          w_state_nxt     = S_HALT;
          w_halt_code_nxt = HALT_TIMEOUT;
        end
      end
      S_WB:    w_state_nxt = S_IF_REQ;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_RESET;
    endcase
  end

  // Fetch completion is the only output allowed to react within the cycle.
  assign inst_latch = w_inst_latch;

  // State register plus Moore outputs, registered from the next state so each
  // output is valid for exactly the cycles spent in its state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_RESET;
      ifu_req_valid <= 1'b0;
      mdu_start     <= 1'b0;
      mem_req_valid <= 1'b0;
      reg_wen       <= 1'b0;
      pc_wen        <= 1'b0;
      pc_redirect   <= 1'b0;
      halted        <= 1'b0;
      halt_code     <= 2'd0;
    end else begin
      r_state       <= w_state_nxt;
      ifu_req_valid <= (w_state_nxt == S_IF_REQ);
      mdu_start     <= (w_state_nxt == S_EX) && dec_mdu;
      mem_req_valid <= (w_state_nxt == S_MEM_REQ);
      reg_wen       <= (w_state_nxt == S_WB) && dec_wreg;
      pc_wen        <= (w_state_nxt == S_WB);
      pc_redirect   <= (w_state_nxt == S_WB) && dec_wpc;
      halted        <= (w_state_nxt == S_HALT);
      halt_code     <= w_halt_code_nxt;
    end
  end

`ifdef YSYX_22050039_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycle   <= 64'd0;
      perf_instret <= 64'd0;
    end else begin
      if ((r_state != S_RESET) && (r_state != S_HALT)) perf_cycle <= perf_cycle + 64'd1;
      if (r_state == S_WB) perf_instret <= perf_instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22050039_core_seq.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050039_core_seq
// Scoreboard bench: the driver issues instructions with random handshake
// delays and pushes the expected retirement (write flags, latency, request
// and pulse counts) computed from the stage-delay sum; a negedge monitor pops
// and compares whenever pc_wen is seen. A second instance with TIMEOUT=4 and
// a stuck fetch ready exercises the watchdog halt.
// ---------------------------------------------------------------------------
module tb_ysyx_22050039_core_seq;

  localparam int K_ALU = 0, K_BR = 1, K_LD = 2, K_ST = 3, K_MDU = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       ifu_req_ready, ifu_resp_valid, mdu_done, mem_req_ready, mem_resp_valid;
  logic       dec_wreg, dec_wpc, dec_mdu, dec_load, dec_store, dec_ebreak, dec_invalid;
  logic       ifu_req_valid, inst_latch, mdu_start, mem_req_valid;
  logic       reg_wen, pc_wen, pc_redirect, halted;
  logic [1:0] halt_code;
  logic       to_ifu_req_valid, to_inst_latch, to_mdu_start, to_mem_req_valid;
  logic       to_reg_wen, to_pc_wen, to_pc_redirect, to_halted;
  logic [1:0] to_halt_code;
`ifdef YSYX_22050039_PERF_CNT_EN
  logic [63:0] perf_cycle, perf_instret, to_perf_cycle, to_perf_instret;
`endif

  ysyx_22050039_core_seq dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_resp_valid(ifu_resp_valid), .inst_latch(inst_latch),
    .dec_wreg(dec_wreg), .dec_wpc(dec_wpc), .dec_mdu(dec_mdu),
    .dec_load(dec_load), .dec_store(dec_store), .dec_ebreak(dec_ebreak),
    .dec_invalid(dec_invalid), .mdu_start(mdu_start), .mdu_done(mdu_done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .reg_wen(reg_wen), .pc_wen(pc_wen),
    .pc_redirect(pc_redirect), .halted(halted), .halt_code(halt_code)
`ifdef YSYX_22050039_PERF_CNT_EN
    , .perf_cycle(perf_cycle), .perf_instret(perf_instret)
`endif
  );

  ysyx_22050039_core_seq #(.TIMEOUT_W(16), .TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst),
    .ifu_req_valid(to_ifu_req_valid), .ifu_req_ready(1'b0),
    .ifu_resp_valid(1'b0), .inst_latch(to_inst_latch),
    .dec_wreg(1'b0), .dec_wpc(1'b0), .dec_mdu(1'b0),
    .dec_load(1'b0), .dec_store(1'b0), .dec_ebreak(1'b0),
    .dec_invalid(1'b0), .mdu_start(to_mdu_start), .mdu_done(1'b0),
    .mem_req_valid(to_mem_req_valid), .mem_req_ready(1'b0),
    .mem_resp_valid(1'b0), .reg_wen(to_reg_wen), .pc_wen(to_pc_wen),
    .pc_redirect(to_pc_redirect), .halted(to_halted), .halt_code(to_halt_code)
`ifdef YSYX_22050039_PERF_CNT_EN
    , .perf_cycle(to_perf_cycle), .perf_instret(to_perf_instret)
`endif
  );

  typedef struct {
    int wreg; int redir; int lat; int ifv; int mreq; int starts; int latches;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   to_done = 1'b0;

  task automatic check(input string name, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  int   m_cyc, m_ifv, m_mreq, m_start, m_latch;
  logic m_prev_ifv, m_prev_mreq, m_prev_mready;
  exp_t m_e;

  always @(negedge clk) begin
    if (!rst) begin
      m_cyc = 0; m_ifv = 0; m_mreq = 0; m_start = 0; m_latch = 0;
      m_prev_ifv = 1'b0; m_prev_mreq = 1'b0; m_prev_mready = 1'b0;
    end else begin
      if (ifu_req_valid && !m_prev_ifv) begin
        m_cyc = 0; m_ifv = 0; m_mreq = 0; m_start = 0; m_latch = 0;
      end
      m_cyc++;
      m_ifv   += int'(ifu_req_valid);
      m_mreq  += int'(mem_req_valid);
      m_start += int'(mdu_start);
      m_latch += int'(inst_latch);
      if (pc_wen) begin
        if (sb.size() == 0) begin
          check("wb_without_instr", int'(pc_wen), 0);
        end else begin
          m_e = sb.pop_front();
          check("reg_wen",       int'(reg_wen),     m_e.wreg);
          check("pc_redirect",   int'(pc_redirect), m_e.redir);
          check("latency",       m_cyc,             m_e.lat);
          check("ifu_req_cycles", m_ifv,            m_e.ifv);
          check("mem_req_cycles", m_mreq,           m_e.mreq);
          check("mdu_start_cnt", m_start,           m_e.starts);
          check("inst_latch_cnt", m_latch,          m_e.latches);
        end
      end
      if (reg_wen && !pc_wen)     check("reg_wen_without_pc_wen", int'(reg_wen), 0);
      if (pc_redirect && !pc_wen) check("redirect_without_pc_wen", int'(pc_redirect), 0);
      if (m_prev_mreq && !m_prev_mready) check("mem_req_hold", int'(mem_req_valid), 1);
      m_prev_ifv    = ifu_req_valid;
      m_prev_mreq   = mem_req_valid;
      m_prev_mready = mem_req_ready;
    end
  end

  // ---------------- driver ----------------
  task automatic set_dec(input int kind, input bit wreg, input bit wpc);
    dec_wreg = wreg; dec_wpc = wpc;
    dec_mdu = (kind == K_MDU); dec_load = (kind == K_LD); dec_store = (kind == K_ST);
    dec_ebreak = 1'b0; dec_invalid = 1'b0;
  endtask

  task automatic wait_fetch_req(output bit ok);
    int n = 0;
    while (!ifu_req_valid && n < 20) begin
      tick();
      n++;
    end
    ok = ifu_req_valid;
    check("fetch_req_seen", int'(ifu_req_valid), 1);
  endtask

  // Starts in the first IF_REQ cycle, ends in the ID cycle.
  task automatic fetch(input int dr, input int rd);
    repeat (dr) begin
      mdu_done = 1'($urandom_range(0, 1));  // stray done outside EX_WAIT
      tick();
    end
    mdu_done = 1'b0;
    ifu_req_ready = 1'b1;
    ifu_resp_valid = (rd == 0);
    tick();
    ifu_req_ready = 1'b0;
    ifu_resp_valid = 1'b0;
    if (rd > 0) begin
      repeat (rd - 1) tick();
      ifu_resp_valid = 1'b1;
      tick();
      ifu_resp_valid = 1'b0;
    end
  endtask

  task automatic run_instr(input int kind, input bit wreg, input bit wpc, input int dr,
                           input int rd, input int md, input int mr, input int mresp);
    exp_t e;
    bit   ok;
    bit   is_mem;
    wait_fetch_req(ok);
    if (!ok) return;
    set_dec(kind, wreg, wpc);
    is_mem    = (kind == K_LD) || (kind == K_ST);
    e.wreg    = int'(wreg);
    e.redir   = int'(wpc);
    e.ifv     = dr + 1;
    e.mreq    = is_mem ? mr + 1 : 0;
    e.starts  = (kind == K_MDU) ? 1 : 0;
    e.latches = 1;
    // fetch + ID + EX + (unit/mem wait) + WB
    e.lat = (dr + 1 + rd) + 2 +
            ((kind == K_MDU) ? md : is_mem ? (mr + 1 + ((kind == K_LD) ? mresp : 0)) : 0) + 1;
    sb.push_back(e);
    fetch(dr, rd);
    tick();  // EX
    if (kind == K_MDU) begin
      tick();
      repeat (md - 1) tick();
      mdu_done = 1'b1;
      tick();
      mdu_done = 1'b0;
    end else if (is_mem) begin
      tick();
      repeat (mr) tick();
      mem_req_ready = 1'b1;
      mem_resp_valid = (kind == K_LD) && (mresp == 0);
      tick();
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      if (kind == K_LD && mresp > 0) begin
        repeat (mresp - 1) tick();
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
      end
    end else begin
      tick();
    end
  endtask

  task automatic run_halt(input bit ebreak, input bit invalid, input int code, input string tag);
    bit ok;
    int n;
    wait_fetch_req(ok);
    if (!ok) return;
    set_dec(K_ALU, 1'b1, 1'b1);
    dec_ebreak = ebreak;
    dec_invalid = invalid;
    fetch(0, 0);
    tick();
    check({tag, "_halted"}, int'(halted), 1);
    check({tag, "_code"}, int'(halt_code), code);
    n = 0;
    repeat (6) begin
      tick();
      n += int'(ifu_req_valid | mem_req_valid | pc_wen | reg_wen | mdu_start);
    end
    check({tag, "_no_requests"}, n, 0);
    check({tag, "_sticky"}, int'(halted), 1);
    dec_ebreak = 1'b0;
    dec_invalid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    check({tag, "_async_halted"}, int'(halted), 0);
    check({tag, "_async_ifu_req"}, int'(ifu_req_valid), 0);
    tick();
    tick();
    rst = 1'b1;
  endtask

  // ---------------- timeout instance ----------------
  initial begin
    int n;
    n = 0;
    wait (rst === 1'b1);
    for (int i = 0; i < 30 && !to_halted; i++) begin
      @(negedge clk);
      if (!to_halted) n += int'(to_ifu_req_valid);
    end
    check("to_halted", int'(to_halted), 1);
    check("to_halt_code", int'(to_halt_code), 2);
    check("to_req_cycles", n, 4);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      n += int'(to_ifu_req_valid | to_mem_req_valid | to_pc_wen | to_reg_wen);
    end
    check("to_no_requests", n, 0);
    to_done = 1'b1;
  end

  // ---------------- main sequence ----------------
  initial begin
    int kind, dr, rd, md, mr, mresp, w;
    bit ok;
    rst = 1'b0;
    ifu_req_ready = 0; ifu_resp_valid = 0; mdu_done = 0; mem_req_ready = 0; mem_resp_valid = 0;
    set_dec(K_ALU, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ifu_req_valid", int'(ifu_req_valid), 0);
    check("rst_inst_latch",    int'(inst_latch), 0);
    check("rst_mdu_start",     int'(mdu_start), 0);
    check("rst_mem_req_valid", int'(mem_req_valid), 0);
    check("rst_reg_wen",       int'(reg_wen), 0);
    check("rst_pc_wen",        int'(pc_wen), 0);
    check("rst_pc_redirect",   int'(pc_redirect), 0);
    check("rst_halted",        int'(halted), 0);
    check("rst_halt_code",     int'(halt_code), 0);
    rst = 1'b1;
    tick();
    check("if_req_after_reset", int'(ifu_req_valid), 1);

    run_instr(K_ALU, 1'b1, 1'b0, 0, 0, 1, 0, 0);   // add, all ready
    run_instr(K_LD,  1'b1, 1'b0, 0, 0, 1, 3, 2);   // delayed load
    run_instr(K_MDU, 1'b1, 1'b0, 0, 0, 33, 0, 0);  // divw
    run_instr(K_BR,  1'b0, 1'b1, 0, 0, 1, 0, 0);   // beq taken
    run_instr(K_ST,  1'b0, 1'b0, 1, 2, 1, 2, 0);

    for (int i = 0; i < 150; i++) begin
      kind  = int'($urandom_range(0, 4));
      dr    = int'($urandom_range(0, 3));
      rd    = int'($urandom_range(0, 3));
      md    = int'($urandom_range(1, 6));
      mr    = int'($urandom_range(0, 3));
      mresp = int'($urandom_range(0, 3));
      w     = int'($urandom_range(0, 3));
      run_instr(kind, w[0], w[1], dr, rd, md, mr, mresp);
    end

    // Abort a load in MEM_WAIT.
    wait_fetch_req(ok);
    set_dec(K_LD, 1'b1, 1'b0);
    fetch(0, 0);
    tick();                 // EX
    tick();                 // MEM_REQ
    mem_req_ready = 1'b1;
    tick();                 // MEM_WAIT
    mem_req_ready = 1'b0;
    tick();                 // still MEM_WAIT
    #2;
    rst = 1'b0;
    #1;
    check("abort_ifu_req_valid", int'(ifu_req_valid), 0);
    check("abort_mem_req_valid", int'(mem_req_valid), 0);
    check("abort_reg_wen",       int'(reg_wen), 0);
    check("abort_pc_wen",        int'(pc_wen), 0);
    check("abort_halted",        int'(halted), 0);
    tick();
    tick();
    rst = 1'b1;
    run_instr(K_ALU, 1'b1, 1'b0, 0, 0, 1, 0, 0);

    run_halt(1'b1, 1'b0, 0, "ebreak");
    do_reset("after_ebreak");
    run_halt(1'b0, 1'b1, 1, "invalid");
    do_reset("after_invalid");
    run_instr(K_BR, 1'b1, 1'b1, 2, 1, 1, 0, 0);
    tick();

    for (int i = 0; i < 200 && !to_done; i++) tick();
    check("timeout_run_done", int'(to_done), 1);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish, vectors=%0d miscompares=%0d",
             vectors, miscompares);
    $fatal(1, "bench time limit reached");
  end

endmodule
